shift_deser_rx: RTL

//  Receive side of the serial link driven by the universal shift register's serial output.

---
 rtl/shift_deser_rx.sv | 117 +++++++++++
 1 files changed

// File: rtl/shift_deser_rx.sv
// rtl/shift_deser_rx.sv - serial-to-parallel receiver with double-buffered valid/ready output
module shift_deser_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             abort,
    input  logic             clr_err
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [0:0]    IDLE  = 1'b0;
    localparam logic [0:0]    SHIFT = 1'b1;
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;
    logic             abort_q, abort_d;
    logic             word_done, ovr_set, abort_set;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        dir_d     = dir_q;
        word_done = 1'b0;
        abort_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                    dir_d    = dir;
                    shreg_d  = '0;
                end
            end
            SHIFT: begin
                // A resync wins over a coincident data bit; that bit is lost with the partial word.
                if (start) begin
                    abort_set = 1'b1;
                    bitcnt_d  = '0;
                    dir_d     = dir;
                    shreg_d   = '0;
                end else if (sin_valid) begin
                    shreg_d  = dir_q ? {sin, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], sin};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == LAST) begin
                        word_done = 1'b1;
                        state_d   = IDLE;
                        bitcnt_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        ovr_set      = 1'b0;
        // A finished word may replace the held one only if that one leaves on this same edge.
        if (word_done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = shreg_d;
                dout_valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
        overrun_d = ovr_set | (overrun_q & ~clr_err);
        abort_d   = abort_set | (abort_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            dir_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            dir_q        <= dir_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            abort_q      <= abort_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == SHIFT);
    assign overrun    = overrun_q;
    assign abort      = abort_q;
endmodule
